mux_4x4: RTL and testbench

MUX_4X4 -- requirements
Module: mux_4x4

---
 rtl/mux_4x4.sv | 55 +++++
 tb/tb_mux_4x4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux_4x4.sv
// 4:1 mux with combinational result and one-hot select decode, plus an enabled capture register.
// Y/SEL_OH are zero-latency; Y_Q/VALID_Q update one CLK edge after capture; no backpressure.
module mux_4x4 #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    input  logic             EN,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_Q,
    output logic [3:0]       SEL_OH,
    output logic             VALID_Q
);

    // An unknown select propagates as X in simulation rather than silently picking a leg.
    always_comb begin
        Y = 'x;
        case (S)
            2'b00:   Y = A;
            2'b01:   Y = B;
            2'b10:   Y = C;
            2'b11:   Y = D;
            default: Y = 'x;
        endcase
    end

    always_comb begin
        SEL_OH = 4'b0000;
        case (S)
            2'b00:   SEL_OH = 4'b0001;
            2'b01:   SEL_OH = 4'b0010;
            2'b10:   SEL_OH = 4'b0100;
            2'b11:   SEL_OH = 4'b1000;
            default: SEL_OH = 'x;
        endcase
    end

    // Reset wins over enable on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Y_Q     <= RESET_VAL;
            VALID_Q <= 1'b0;
        end else if (EN) begin
            Y_Q     <= Y;
            VALID_Q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_4x4.sv
// Directed and randomized checks of mux_4x4 against hand-computed values and a small reference model.
module tb_mux_4x4;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] a, b, c, d;
    logic [1:0] s;
    logic [3:0] y, y_q, sel_oh;
    logic       valid_q;

    int errors = 0;
    int checks = 0;

    mux_4x4 #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .CLK(clk), .RST(rst), .A(a), .B(b), .C(c), .D(d), .S(s), .EN(en),
        .Y(y), .Y_Q(y_q), .SEL_OH(sel_oh), .VALID_Q(valid_q)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        a = 4'b1111; b = 4'b0000; c = 4'b1010; d = 4'b0110; s = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (y_q !== 4'b0000) begin
            errors++; $display("FAIL reset_y_q actual=%b expected=0000", y_q);
        end
        checks++;
        if (valid_q !== 1'b0) begin
            errors++; $display("FAIL reset_valid actual=%b expected=0", valid_q);
        end
        checks++;
        if (y !== 4'b1010) begin
            errors++; $display("FAIL reset_y_live actual=%b expected=1010", y);
        end
    endtask

    // Sweep runs with RST still high: Y and SEL_OH must be unaffected by reset.
    task automatic test_comb_sweep();
        logic [3:0] exp_y  [4] = '{4'b1111, 4'b0000, 4'b1010, 4'b0110};
        logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #1;
            checks++;
            if (y !== exp_y[i]) begin
                errors++; $display("FAIL sweep_y s=%0d actual=%b expected=%b", i, y, exp_y[i]);
            end
            checks++;
            if (sel_oh !== exp_oh[i]) begin
                errors++; $display("FAIL sweep_oh s=%0d actual=%b expected=%b", i, sel_oh, exp_oh[i]);
            end
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; s = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (y_q !== 4'b1010) begin
            errors++; $display("FAIL capture_y_q actual=%b expected=1010", y_q);
        end
        checks++;
        if (valid_q !== 1'b1) begin
            errors++; $display("FAIL capture_valid actual=%b expected=1", valid_q);
        end
        #2 s = 2'b11;
        #1;
        checks++;
        if (y !== 4'b0110) begin
            errors++; $display("FAIL midcycle_y actual=%b expected=0110", y);
        end
        checks++;
        if (y_q !== 4'b1010) begin
            errors++; $display("FAIL midcycle_y_q actual=%b expected=1010", y_q);
        end
        @(posedge clk); #1;
        checks++;
        if (y_q !== 4'b0110) begin
            errors++; $display("FAIL next_edge_y_q actual=%b expected=0110", y_q);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b1; s = 2'b10;
        @(negedge clk);
        en = 1'b0; s = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (y !== 4'b0000) begin
                errors++; $display("FAIL hold_y edge=%0d actual=%b expected=0000", i, y);
            end
            checks++;
            if (y_q !== 4'b1010 || valid_q !== 1'b1) begin
                errors++; $display("FAIL hold_y_q edge=%0d actual=%b/%b expected=1010/1", i, y_q, valid_q);
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; s = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (y_q !== 4'b0000 || valid_q !== 1'b0) begin
            errors++; $display("FAIL rst_priority actual=%b/%b expected=0000/0", y_q, valid_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] exp_q = 4'b0000;
        logic       exp_v = 1'b0;
        logic [3:0] ref_y;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
            s = 2'($urandom); en = 1'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            case (s)
                2'b00: ref_y = a;
                2'b01: ref_y = b;
                2'b10: ref_y = c;
                default: ref_y = d;
            endcase
            #1;
            checks++;
            if (y !== ref_y) begin
                errors++; $display("FAIL rand_y n=%0d actual=%b expected=%b", n, y, ref_y);
            end
            if (rst) begin
                exp_q = 4'b0000; exp_v = 1'b0;
            end else if (en) begin
                exp_q = ref_y; exp_v = 1'b1;
            end
            @(posedge clk); #1;
            checks++;
            if (y_q !== exp_q || valid_q !== exp_v) begin
                errors++; $display("FAIL rand_y_q n=%0d actual=%b/%b expected=%b/%b", n, y_q, valid_q, exp_q, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s = 2'b00;
        a = '0; b = '0; c = '0; d = '0;
        test_reset();
        test_comb_sweep();
        test_capture();
        test_hold();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
